instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch front end; the producer that drives instr/ce into instr_decoder.
//  - Keeps the fetch PC and issues in-order word reads to instruction memory over a req/gnt + rvalid interface.
//  - Buffers returned words with their PCs in a small FIFO.
//  - Presents one instruction per cycle to the decoder, which can apply backpressure with stall.
//  - Redirect (jump/branch) flushes the FIFO and every in-flight fetch, then restarts at the new PC.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC loaded at reset
//  FIFO_DEPTH  2              instr/PC buffer entries; power of 2, >=2; also max outstanding reads
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   read request to instruction memory
//  imem_addr    out  32  word-aligned read address; bits [1:0] always 0
//  imem_gnt     in   1   memory accepts the request this cycle (req & gnt = issue)
//  imem_rvalid  in   1   read data valid; exactly one per issue, in issue order, >=1 cycle after gnt
//  imem_rdata   in   32  instruction word
//  redirect     in   1   flush and restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch PC; bits [1:0] ignored (forced to 0)
//  stall        in   1   decoder not ready; head entry is held
//  instr        out  32  instruction word to decoder (instr_t.word)
//  pc           out  32  PC of instr
//  ce           out  1   instr/pc valid; decoder consumes when ce & !stall
// BEHAVIOUR
//  Reset values (async on rst_n=0): imem_req=0, imem_addr=RESET_PC, ce=0, instr=0, pc=RESET_PC, FIFO empty, counters 0.
//  Issue:
//  - imem_req=1 when outstanding+fifo_count < FIFO_DEPTH, using registered values (conservative credit); first request one cycle after rst_n rises.
//  - Once raised, imem_req and imem_addr hold until gnt; redirect is the only exception.
//  - On req&gnt: fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), outstanding++, issued PC pushed to an address queue.
//  Response:
//  - imem_rvalid with discard_cnt==0: {rdata, queue head PC} written into the FIFO, outstanding--.
//  - imem_rvalid with discard_cnt!=0: word dropped, discard_cnt--, outstanding--.
//  - Response before any issue is a protocol error (assertion only).
//  Output:
//  - FIFO is registered: ce rises the cycle after the accepting rvalid. ce = FIFO non-empty; instr/pc = head.
//  - Pop when ce & !stall. While stall=1, instr/pc/ce are held stable.
//  - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
//  Redirect (takes priority over all same-cycle events):
//  - FIFO and address queue cleared; the head is not consumed even if stall=0.
//  - discard_cnt = outstanding, minus 1 if an rvalid arrives that same cycle (that word is also dropped).
//  - A request granted in the redirect cycle is counted as outstanding and discarded.
//  - fetch_pc = {redirect_pc[31:2],2'b00}; imem_req=0 next cycle; request at the new PC the cycle after.
//  - ce=0 from the cycle after redirect until the first post-redirect word returns.
//  - Redirect while discard_cnt!=0: discard_cnt accumulates the remaining outstanding responses.
//  Counters: outstanding and discard_cnt are $clog2(FIFO_DEPTH)+1 bits; never exceed FIFO_DEPTH.
//  Overflow/underflow are impossible by the credit rule and are checked by assertions.
//  Reset mid-operation: all state cleared immediately. Memory responses in flight at reset are
//  the memory's responsibility; the block ignores rvalid while rst_n=0.
// TESTING
//  1 Reset: rst_n=0 -> req=0, ce=0, pc=0; release, gnt=1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles.
//  2 Stream, 1-cycle memory, words 0x000005B7,0x00001517,0x00000637,0x00000013
//    -> ce every cycle after warm-up; (pc,instr) = (0x0,0x000005B7),(0x4,0x00001517),(0x8,...),(0xC,...) in order.
//  3 stall=1 for 6 cycles, FIFO_DEPTH=2 -> at most 2 issues; no issue while full; stall=0 -> pc 0x0, then 0x4, no loss or duplicate.
//  4 Redirect to 0x100 with 2 outstanding, rvalid in the same cycle -> both stale words dropped; next ce shows pc=0x100; imem_addr 0x100, 0x104.
//  5 redirect_pc=0x00000103 -> imem_addr=0x100, pc=0x100; redirect in a stall cycle with ce=1 -> head discarded.
//  6 rst_n pulsed low mid-stream -> ce=0, imem_req=0 in the same cycle (async); refetch from RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch front end: issues in-order word reads, buffers returned words
// with their PCs, and hands one instruction per cycle to the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        ce
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = PW + 1;
    localparam logic [CW:0] DEPTH_SUM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] PC_MASK   = 32'hFFFF_FFFC;

    logic [31:0]   fetch_pc;
    logic          req_q;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] fifo_count;

    logic [31:0]   aq_pc [FIFO_DEPTH];
    logic [PW-1:0] aq_rd;
    logic [PW-1:0] aq_wr;

    logic [31:0]   fifo_word [FIFO_DEPTH];
    logic [31:0]   fifo_pc [FIFO_DEPTH];
    logic [PW-1:0] fifo_rd;
    logic [PW-1:0] fifo_wr;

    logic          issue;
    logic          accept;
    logic          drop;
    logic          pop;
    logic          req_next;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] discard_next;
    logic [CW-1:0] count_next;
    logic [CW:0]   credit_sum;

    always_comb begin
        issue            = req_q & imem_gnt;
        drop             = imem_rvalid & (discard_cnt != '0);
        accept           = imem_rvalid & (discard_cnt == '0) & ~redirect;
        pop              = (fifo_count != '0) & ~stall & ~redirect;
        outstanding_next = outstanding + CW'(issue) - CW'(imem_rvalid);
        discard_next     = discard_cnt - CW'(drop);
        count_next       = fifo_count + CW'(accept) - CW'(pop);
        if (redirect) begin
            // Every read still in flight (including one granted right now) is stale.
            discard_next = outstanding_next;
            count_next   = '0;
        end
        credit_sum = {1'b0, outstanding_next} + {1'b0, count_next};
        if (redirect) begin
            req_next = 1'b0;
        end else if (req_q && !imem_gnt) begin
            req_next = 1'b1;
        end else begin
            req_next = credit_sum < DEPTH_SUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC & PC_MASK;
            req_q       <= 1'b0;
            outstanding <= '0;
            discard_cnt <= '0;
            fifo_count  <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
        end else begin
            req_q       <= req_next;
            outstanding <= outstanding_next;
            discard_cnt <= discard_next;
            fifo_count  <= count_next;
            if (redirect) begin
                fetch_pc <= redirect_pc & PC_MASK;
                aq_rd    <= '0;
                aq_wr    <= '0;
                fifo_rd  <= '0;
                fifo_wr  <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    aq_wr    <= aq_wr + PW'(1);
                end
                if (accept) begin
                    aq_rd   <= aq_rd + PW'(1);
                    fifo_wr <= fifo_wr + PW'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue && !redirect) begin
            aq_pc[aq_wr] <= fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_word[i] <= '0;
                fifo_pc[i]   <= RESET_PC;
            end
        end else if (accept) begin
            fifo_word[fifo_wr] <= imem_rdata;
            fifo_pc[fifo_wr]   <= aq_pc[aq_rd];
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = fetch_pc;
    assign ce        = fifo_count != '0;
    assign instr     = fifo_word[fifo_rd];
    assign pc        = fifo_pc[fifo_rd];

    // Credit rule guarantees these; a violation means a memory protocol error.
    a_rvalid_issued : assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> outstanding != '0);
    a_out_bound : assert property (@(posedge clk) disable iff (!rst_n)
        outstanding <= CW'(FIFO_DEPTH));
    a_fifo_bound : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CW'(FIFO_DEPTH));
    a_discard_bound : assert property (@(posedge clk) disable iff (!rst_n)
        discard_cnt <= outstanding);
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queued memory model and a consumer monitor.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ce;

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
        .instr(instr), .pc(pc), .ce(ce)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic        hold = 1'b0;
    logic [31:0] pendq[$];
    logic [31:0] issued[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_05B7;
            32'h0000_0004: return 32'h0000_1517;
            32'h0000_0008: return 32'h0000_0637;
            32'h0000_000C: return 32'h0000_0013;
            default:       return 32'hC0DE_0000 ^ a;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs are set at the negedge; this evaluates memory/consumer for the coming posedge.
    task automatic cyc();
        if (!rst_n) begin
            pendq.delete();
            imem_rvalid = 1'b0;
        end else begin
            if (!hold && pendq.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pendq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
            end
            if (imem_req && imem_gnt) begin
                pendq.push_back(imem_addr);
                issued.push_back(imem_addr);
            end
            if (ce && !stall && !redirect) begin
                got_pc.push_back(pc);
                got_ins.push_back(instr);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic clear_logs();
        issued.delete();
        got_pc.delete();
        got_ins.delete();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        stall       = 1'b0;
        hold        = 1'b0;
        imem_rvalid = 1'b0;
        pendq.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic check_got(input string tag, input int i, input logic [31:0] exp_pc);
        logic [31:0] p;
        logic [31:0] w;
        p = (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
        w = (i < got_ins.size()) ? got_ins[i] : 32'hDEAD_BEEF;
        check_val({tag, "_pc"}, p, exp_pc);
        check_val({tag, "_instr"}, w, mem_word(exp_pc));
    endtask

    task automatic check_iss(input string tag, input int i, input logic [31:0] exp);
        logic [31:0] a;
        a = (i < issued.size()) ? issued[i] : 32'hDEAD_BEEF;
        check_val(tag, a, exp);
    endtask

    initial begin
        // reset values
        #2;
        check_val("rst_req", 32'(imem_req), 32'd0);
        check_val("rst_ce", 32'(ce), 32'd0);
        check_val("rst_pc", pc, 32'h0);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_addr", imem_addr, 32'h0);
        @(negedge clk);
        cyc();
        rst_n = 1'b1;

        // first requests after release, then a plain stream
        imem_gnt = 1'b1;
        cyc();
        check_val("t1_req_first", 32'(imem_req), 32'd1);
        check_val("t1_addr0", imem_addr, 32'h0);
        cyc();
        check_val("t1_addr1", imem_addr, 32'h4);
        check_val("t1_req_second", 32'(imem_req), 32'd1);
        cyc();
        check_val("t1_addr2", imem_addr, 32'h8);
        check_val("t2_ce_rise", 32'(ce), 32'd1);
        check_val("t2_pc_head", pc, 32'h0);
        check_val("t2_instr_head", instr, 32'h0000_05B7);
        run(20);
        check_val("t2_w0_pc", got_pc.size() > 0 ? got_pc[0] : 32'hDEAD_BEEF, 32'h0);
        check_val("t2_w0", got_ins.size() > 0 ? got_ins[0] : 32'hDEAD_BEEF, 32'h0000_05B7);
        check_val("t2_w1", got_ins.size() > 1 ? got_ins[1] : 32'hDEAD_BEEF, 32'h0000_1517);
        check_val("t2_w2", got_ins.size() > 2 ? got_ins[2] : 32'hDEAD_BEEF, 32'h0000_0637);
        check_val("t2_w3", got_ins.size() > 3 ? got_ins[3] : 32'hDEAD_BEEF, 32'h0000_0013);
        for (int i = 0; i < 6; i++) check_got("t2_seq", i, 32'(4 * i));

        // stall from the start: FIFO fills, issue stops, nothing consumed
        do_reset();
        clear_logs();
        stall = 1'b1;
        run(6);
        check_val("t3_issues", 32'(issued.size()), 32'd2);
        check_val("t3_ce", 32'(ce), 32'd1);
        check_val("t3_pc_held", pc, 32'h0);
        check_val("t3_instr_held", instr, 32'h0000_05B7);
        check_val("t3_none_taken", 32'(got_pc.size()), 32'd0);
        run(2);
        check_val("t3_issues_still", 32'(issued.size()), 32'd2);
        check_val("t3_pc_still", pc, 32'h0);
        stall = 1'b0;
        run(10);
        check_got("t3_r0", 0, 32'h0);
        check_got("t3_r1", 1, 32'h4);
        check_got("t3_r2", 2, 32'h8);

        // redirect with two reads outstanding, one returning in the redirect cycle
        do_reset();
        hold = 1'b1;
        run(3);
        check_val("t4_req_blocked", 32'(imem_req), 32'd0);
        clear_logs();
        hold        = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        cyc();
        redirect = 1'b0;
        issued.delete();
        check_val("t4_req_low", 32'(imem_req), 32'd0);
        check_val("t4_ce_low", 32'(ce), 32'd0);
        check_val("t4_addr", imem_addr, 32'h100);
        cyc();
        check_val("t4_req_back", 32'(imem_req), 32'd1);
        check_val("t4_addr_hold", imem_addr, 32'h100);
        run(12);
        check_iss("t4_iss0", 0, 32'h100);
        check_iss("t4_iss1", 1, 32'h104);
        check_got("t4_r0", 0, 32'h100);
        check_got("t4_r1", 1, 32'h104);

        // unaligned redirect while stalled with a valid head
        stall = 1'b1;
        run(4);
        check_val("t5_ce_before", 32'(ce), 32'd1);
        clear_logs();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        cyc();
        redirect = 1'b0;
        stall    = 1'b0;
        issued.delete();
        check_val("t5_addr", imem_addr, 32'h100);
        check_val("t5_ce_low", 32'(ce), 32'd0);
        run(10);
        check_iss("t5_iss0", 0, 32'h100);
        check_got("t5_r0", 0, 32'h100);

        // asynchronous reset mid-stream
        run(3);
        #3;
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        pendq.delete();
        #1;
        check_val("t6_ce_async", 32'(ce), 32'd0);
        check_val("t6_req_async", 32'(imem_req), 32'd0);
        check_val("t6_pc_async", pc, 32'h0);
        check_val("t6_addr_async", imem_addr, 32'h0);
        cyc();
        rst_n = 1'b1;
        clear_logs();
        run(15);
        check_iss("t6_iss0", 0, 32'h0);
        check_iss("t6_iss1", 1, 32'h4);
        check_got("t6_r0", 0, 32'h0);
        check_got("t6_r1", 1, 32'h4);

        // redirect near the top of the address space: fetch PC wraps to 0
        clear_logs();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cyc();
        redirect = 1'b0;
        issued.delete();
        run(16);
        check_iss("t7_iss0", 0, 32'hFFFF_FFF8);
        check_iss("t7_iss1", 1, 32'hFFFF_FFFC);
        check_iss("t7_iss2", 2, 32'h0);
        check_got("t7_r0", 0, 32'hFFFF_FFF8);
        check_got("t7_r1", 1, 32'hFFFF_FFFC);
        check_got("t7_r2", 2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
